// File: rtl/div_iter.sv
// div_iter -- sequential radix-2 restoring divider for the RV64M execute stage.
// Serves DIV/DIVU/REM/REMU and their W forms, one quotient bit per cycle.
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   div_valid / div_ready  request handshake (div_ready registered, high when idle)
//   flush                  abort the request in flight; wins over div_valid
//   divw, div_signed       32-bit (W) op / signed operands
//   dividend, divisor      64-bit operands, latched at acceptance
//   out_valid              registered one-cycle result pulse
//   quotient, remainder    result registers, held until the next result
//
// Build option: DIV_FASTPATH_EN -- when defined, a zero divisor skips the
// iteration and goes straight to DONE (out_valid one cycle after acceptance).
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        flush,
  input  logic        divw,
  input  logic        div_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Per-request context captured at acceptance.
  typedef struct packed {
    logic        is_w;
    logic        neg_q;    // operand signs differ
    logic        neg_r;    // dividend negative
    logic        div0;     // divisor zero after W extension
    logic [63:0] ext_dvd;  // extended dividend, the div-by-zero remainder
    logic [63:0] dvsr;     // divisor magnitude
  } ctx_t;

  function automatic logic [63:0] wsext(input logic w, input logic [63:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  logic [1:0]  state;
  logic [5:0]  cnt;
  ctx_t        ctx;
  logic [64:0] rem;   // partial remainder
  logic [63:0] quo;   // dividend bits shift out the top, quotient bits in the bottom

  // ---------------- operand conditioning ----------------
  logic [63:0] ext_a, ext_b, mag_a, mag_b;
  logic        sgn_a, sgn_b, b_zero, accept;

  always_comb begin
    ext_a  = divw ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
    ext_b  = divw ? {{32{div_signed & divisor[31]}},  divisor[31:0]}  : divisor;
    sgn_a  = div_signed & ext_a[63];
    sgn_b  = div_signed & ext_b[63];
    // -2^63 negates to itself, which read as unsigned is the correct magnitude.
    mag_a  = sgn_a ? (~ext_a + 64'd1) : ext_a;
    mag_b  = sgn_b ? (~ext_b + 64'd1) : ext_b;
    b_zero = (ext_b == 64'd0);
    accept = (state == S_IDLE) && div_valid && !flush;
  end

  // ---------------- iteration step ----------------
  // rem < divisor always holds, so the 66-bit shifted value cannot overflow and
  // bit 65 of the difference is a clean borrow.
  logic [65:0] shifted, diff;
  logic        qbit;
  logic [5:0]  last;

  always_comb begin
    shifted = {rem, quo[63]};
    diff    = shifted - {2'b00, ctx.dvsr};
    qbit    = ~diff[65];
    last    = ctx.is_w ? 6'd31 : 6'd63;
  end

  // ---------------- sign fix / overrides ----------------
  logic [63:0] q_fix, r_fix;

  always_comb begin
    q_fix = ctx.neg_q ? (~quo + 64'd1) : quo;
    r_fix = ctx.neg_r ? (~rem[63:0] + 64'd1) : rem[63:0];
    if (ctx.div0) begin
      q_fix = '1;
      r_fix = ctx.ext_dvd;
    end
    // W results are sign-extended from bit 31 even for DIVUW/REMUW.
    q_fix = wsext(ctx.is_w, q_fix);
    r_fix = wsext(ctx.is_w, r_fix);
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ctx       <= '0;
      rem       <= '0;
      quo       <= '0;
      div_ready <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush && state != S_IDLE) begin
        state     <= S_IDLE;
        cnt       <= '0;
        div_ready <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            ctx.is_w    <= divw;
            ctx.neg_q   <= sgn_a ^ sgn_b;
            ctx.neg_r   <= sgn_a;
            ctx.div0    <= b_zero;
            ctx.ext_dvd <= ext_a;
            ctx.dvsr    <= mag_b;
            rem         <= '0;
            // W ops left-justify the 32-bit magnitude so the quotient lands in [31:0].
            quo         <= divw ? {mag_a[31:0], 32'd0} : mag_a;
            cnt         <= '0;
            div_ready   <= 1'b0;
`ifdef DIV_FASTPATH_EN
            if (b_zero) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= wsext(divw, ext_a);
            end else begin
              state     <= S_ITER;
            end
`else
            state       <= S_ITER;
`endif
          end
          S_ITER: begin
            rem <= qbit ? diff[64:0] : shifted[64:0];
            quo <= {quo[62:0], qbit};
            cnt <= cnt + 6'd1;
            if (cnt == last) begin
              state <= S_FIX;
              cnt   <= '0;
            end
          end
          S_FIX: begin
            quotient  <= q_fix;
            remainder <= r_fix;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
          default: begin  // S_DONE
            state     <= S_IDLE;
            div_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: reset values, signed/unsigned/W arithmetic,
// overflow, divide-by-zero, back-to-back issue, flush and mid-op reset.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid, div_ready, flush, divw, div_signed, out_valid;
  logic [63:0] dividend, divisor, quotient, remainder;

  int errors = 0;
  int checks = 0;

  div_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .flush      (flush),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

`ifdef DIV_FASTPATH_EN
  localparam int LAT0_64 = 1;
  localparam int LAT0_W  = 1;
`else
  localparam int LAT0_64 = 66;
  localparam int LAT0_W  = 34;
`endif

  // Present one request at a negedge; returns 1ns after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
  endtask

  // Count cycles until out_valid (cycle after the accepting edge = 1), bounded.
  task automatic wait_done(output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (div_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (div_ready) rdy_seen = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; div_valid = 1'b0; flush = 1'b0; divw = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL reset div_ready got %b expected 1", div_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b expected 0", out_valid); end
    checks++; if (quotient !== 64'd0) begin errors++; $display("FAIL reset quotient got %h expected 0", quotient); end
    checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL reset remainder got %h expected 0", remainder); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Arithmetic table, issued back-to-back: each op goes in the cycle div_ready rises.
  task automatic test_arith;
    logic [63:0] t_a [8];
    logic [63:0] t_b [8];
    logic [63:0] t_q [8];
    logic [63:0] t_r [8];
    logic        t_w [8];
    logic        t_s [8];
    int          t_l [8];
    int lat; bit rdy;
    t_a = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'hABCD_0000_FFFF_FFFF,
            64'h1234_5678_FFFF_FF9C};
    t_b = '{64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_0000_0001,
            64'h0000_0000_0000_0007};
    t_q = '{64'd14, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0000,
            64'd1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF2};
    t_r = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
            64'h7FFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
    t_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t_l = '{66, 66, 66, 66, 66, 34, 34, 34};
    for (int i = 0; i < 8; i++) begin
      issue(t_a[i], t_b[i], t_w[i], t_s[i]);
      wait_done(lat, rdy);
      checks++; if (lat !== t_l[i]) begin errors++; $display("FAIL arith[%0d] latency got %0d expected %0d", i, lat, t_l[i]); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL arith[%0d] div_ready high while busy got %b expected 0", i, rdy); end
      checks++; if (quotient !== t_q[i]) begin errors++; $display("FAIL arith[%0d] quotient got %h expected %h", i, quotient, t_q[i]); end
      checks++; if (remainder !== t_r[i]) begin errors++; $display("FAIL arith[%0d] remainder got %h expected %h", i, remainder, t_r[i]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arith[%0d] out_valid not a pulse got %b expected 0", i, out_valid); end
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL arith[%0d] div_ready after done got %b expected 1", i, div_ready); end
    end
  endtask

  task automatic test_div_zero;
    int lat; bit rdy;
    // DIVU/REMU by zero
    issue(64'h1234, 64'd0, 1'b0, 1'b0);
    wait_done(lat, rdy);
    checks++; if (lat !== LAT0_64) begin errors++; $display("FAIL div0_64 latency got %0d expected %0d", lat, LAT0_64); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL div0_64 div_ready high while busy got %b expected 0", rdy); end
    checks++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div0_64 quotient got %h expected all ones", quotient); end
    checks++; if (remainder !== 64'h1234) begin errors++; $display("FAIL div0_64 remainder got %h expected 1234", remainder); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div0_64 out_valid not a pulse got %b expected 0", out_valid); end
    checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL div0_64 div_ready after done got %b expected 1", div_ready); end
    // DIVW/REMW by zero: divisor upper half nonzero but low word zero
    issue(64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1);
    wait_done(lat, rdy);
    checks++; if (lat !== LAT0_W) begin errors++; $display("FAIL div0_w latency got %0d expected %0d", lat, LAT0_W); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL div0_w div_ready high while busy got %b expected 0", rdy); end
    checks++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div0_w quotient got %h expected all ones", quotient); end
    checks++; if (remainder !== 64'hFFFF_FFFF_8000_0005) begin errors++; $display("FAIL div0_w remainder got %h expected ffffffff80000005", remainder); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div0_w out_valid not a pulse got %b expected 0", out_valid); end
    checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL div0_w div_ready after done got %b expected 1", div_ready); end
  endtask

  task automatic test_flush;
    int lat; bit rdy;
    issue(64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL flush div_ready got %b expected 1", div_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got %b expected 0", out_valid); end
    checks++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL flush quotient changed got %h expected all ones", quotient); end
    checks++; if (remainder !== 64'hFFFF_FFFF_8000_0005) begin errors++; $display("FAIL flush remainder changed got %h expected ffffffff80000005", remainder); end
    issue(64'd9, 64'd3, 1'b0, 1'b0);
    wait_done(lat, rdy);
    checks++; if (lat !== 66) begin errors++; $display("FAIL flush_next latency got %0d expected 66", lat); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL flush_next div_ready high while busy got %b expected 0", rdy); end
    checks++; if (quotient !== 64'd3) begin errors++; $display("FAIL flush_next quotient got %h expected 3", quotient); end
    checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL flush_next remainder got %h expected 0", remainder); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_next out_valid not a pulse got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_iter;
    int lat; bit rdy;
    issue(64'hFFFF, 64'd3, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL rst_mid div_ready got %b expected 1", div_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got %b expected 0", out_valid); end
    checks++; if (quotient !== 64'd0) begin errors++; $display("FAIL rst_mid quotient got %h expected 0", quotient); end
    checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL rst_mid remainder got %h expected 0", remainder); end
    issue(64'd100, 64'd7, 1'b0, 1'b0);
    wait_done(lat, rdy);
    checks++; if (lat !== 66) begin errors++; $display("FAIL rst_next latency got %0d expected 66", lat); end
    checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL rst_next quotient got %h expected e", quotient); end
    checks++; if (remainder !== 64'd2) begin errors++; $display("FAIL rst_next remainder got %h expected 2", remainder); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_div_zero;
    test_flush;
    test_reset_mid_iter;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
